// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht
// Branch target buffer with per-entry saturating direction counters.
// Lookup is combinational on the fetch PC and reads only registered state.
// Resolved branches come back through a single registered update port.
// Define BP_GSHARE_EN to XOR a global history register into the table index.
module branch_predictor_bht #(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 8,
    parameter int GHR_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lk_pc_i,
    output logic        lk_hit_o,
    output logic        lk_taken_o,
    output logic [31:0] lk_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_mispred_i,
    input  logic        flush_i,
    output logic [31:0] lookups_o,
    output logic [31:0] mispreds_o
);

    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = TAG_LO + TAG_W - 1;

    // Counter encodings: the MSB of the counter is the taken prediction.
    localparam int               CNT_WNT_INT = (1 << (CNT_W - 1)) - 1;
    localparam int               CNT_WT_INT  = 1 << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_WNT_INT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_WT_INT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    // Table state. Every entry needs a defined counter value out of reset,
    // so the table lives in flops rather than in a RAM macro.
    logic             valid_reg  [ENTRIES];
    logic [TAG_W-1:0] tag_reg    [ENTRIES];
    logic [CNT_W-1:0] cnt_reg    [ENTRIES];
    logic [31:0]      target_reg [ENTRIES];

    logic [31:0] lookups_reg;
    logic [31:0] mispreds_reg;

    // PC-derived index and tag for both ports.
    logic [IDX_W-1:0] lk_pc_idx;
    logic [IDX_W-1:0] upd_pc_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] upd_tag;
    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;

    assign lk_pc_idx  = lk_pc_i[IDX_W+1:2];
    assign upd_pc_idx = upd_pc_i[IDX_W+1:2];
    assign lk_tag     = lk_pc_i[TAG_HI:TAG_LO];
    assign upd_tag    = upd_pc_i[TAG_HI:TAG_LO];

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_reg;

    // Both ports hash with the same (pre-shift) history value.
    assign lk_idx  = lk_pc_idx ^ IDX_W'(ghr_reg);
    assign upd_idx = upd_pc_idx ^ IDX_W'(ghr_reg);

    // Global history: shifts in each resolved direction, cleared by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_reg <= '0;
        end else if (flush_i) begin
            ghr_reg <= '0;
        end else if (upd_valid_i) begin
            ghr_reg <= {ghr_reg[GHR_W-2:0], upd_taken_i};
        end
    end
`else
    logic [GHR_W-1:0] unused_ghr;

    assign unused_ghr = '0;
    assign lk_idx     = lk_pc_idx;
    assign upd_idx    = upd_pc_idx;
`endif

    // Offset bits and bits above the tag do not take part in the update.
    logic unused_upd_pc_bits;
    assign unused_upd_pc_bits = ^{upd_pc_i[1:0], upd_pc_i[31:TAG_HI+1]};

    // Lookup: pure read of the registered table, no bypass from the update port.
    logic             lk_hit;
    logic             lk_taken;
    logic [31:0]      lk_fallthrough;

    always_comb begin
        lk_fallthrough = lk_pc_i + 32'd4;
        lk_hit         = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
        lk_taken       = lk_hit && cnt_reg[lk_idx][CNT_W-1];
    end

    assign lk_hit_o    = lk_hit;
    assign lk_taken_o  = lk_taken;
    assign lk_target_o = lk_taken ? target_reg[lk_idx] : lk_fallthrough;

    // Update-side read of the addressed entry and the saturated counter steps.
    logic             upd_hit;
    logic [CNT_W-1:0] upd_cnt;
    logic [CNT_W-1:0] cnt_up;
    logic [CNT_W-1:0] cnt_down;

    always_comb begin
        upd_hit  = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
        upd_cnt  = cnt_reg[upd_idx];
        cnt_up   = (upd_cnt == CNT_MAX) ? upd_cnt : upd_cnt + CNT_W'(1);
        cnt_down = (upd_cnt == '0)      ? upd_cnt : upd_cnt - CNT_W'(1);
    end

    // Table write: reset clears everything, flush drops only the valid bits
    // and wins over a same-cycle update; otherwise train or allocate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i]  <= 1'b0;
                tag_reg[i]    <= '0;
                cnt_reg[i]    <= CNT_WEAK_NT;
                target_reg[i] <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i] <= 1'b0;
            end
        end else if (upd_valid_i) begin
            if (upd_hit) begin
                if (upd_taken_i) begin
                    cnt_reg[upd_idx]    <= cnt_up;
                    target_reg[upd_idx] <= upd_target_i;
                end else begin
                    cnt_reg[upd_idx] <= cnt_down;
                end
            end else if (upd_taken_i) begin
                // A taken miss claims the slot, evicting whatever alias was there.
                valid_reg[upd_idx]  <= 1'b1;
                tag_reg[upd_idx]    <= upd_tag;
                cnt_reg[upd_idx]    <= CNT_WEAK_T;
                target_reg[upd_idx] <= upd_target_i;
            end
        end
    end

    // Statistics: count every update strobe, flush or not; wrap freely.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lookups_reg  <= '0;
            mispreds_reg <= '0;
        end else if (upd_valid_i) begin
            lookups_reg <= lookups_reg + 32'd1;
            if (upd_mispred_i) begin
                mispreds_reg <= mispreds_reg + 32'd1;
            end
        end
    end

    assign lookups_o  = lookups_reg;
    assign mispreds_o = mispreds_reg;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht
// Directed table of vectors, a randomized phase checked against a behavioural
// model, and a hand-written asynchronous reset sequence.
module tb_branch_predictor_bht;

    localparam int ENTRIES = 64;
    localparam int CNT_W   = 2;
    localparam int TAG_W   = 8;
    localparam int CNT_TOP = (1 << CNT_W) - 1;
    localparam int CNT_MID = 1 << (CNT_W - 1);

    logic        clk;
    logic        rst;
    logic [31:0] lk_pc_i;
    logic        lk_hit_o;
    logic        lk_taken_o;
    logic [31:0] lk_target_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_mispred_i;
    logic        flush_i;
    logic [31:0] lookups_o;
    logic [31:0] mispreds_o;

    int n_vec;
    int n_bad;

    branch_predictor_bht dut (
        .clk           (clk),
        .rst           (rst),
        .lk_pc_i       (lk_pc_i),
        .lk_hit_o      (lk_hit_o),
        .lk_taken_o    (lk_taken_o),
        .lk_target_o   (lk_target_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i),
        .upd_mispred_i (upd_mispred_i),
        .flush_i       (flush_i),
        .lookups_o     (lookups_o),
        .mispreds_o    (mispreds_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // One record per slot; counter is a plain integer in [0, CNT_TOP].
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    logic [31:0] m_lookups;
    logic [31:0] m_mispreds;

    function automatic int m_slot(input logic [31:0] pc);
        int unsigned p;
        p = pc;
        return int'((p / 4) % ENTRIES);
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        int unsigned p;
        p = pc;
        return (p / (4 * ENTRIES)) % (1 << TAG_W);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_cnt[i]   = CNT_MID - 1;
            m_tgt[i]   = 32'h0;
        end
        m_lookups  = 32'h0;
        m_mispreds = 32'h0;
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output bit h, output bit t,
                                     output logic [31:0] tg);
        int s;
        s  = m_slot(pc);
        h  = m_valid[s] && (m_tag[s] == m_tagof(pc));
        t  = h && (m_cnt[s] >= CNT_MID);
        tg = t ? m_tgt[s] : pc + 32'd4;
    endfunction

    // Applies the inputs currently on the pins, as the clock edge does.
    function automatic void m_update();
        int s;
        bit h;
        if (upd_valid_i) begin
            m_lookups = m_lookups + 32'd1;
            if (upd_mispred_i) m_mispreds = m_mispreds + 32'd1;
        end
        if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        end else if (upd_valid_i) begin
            s = m_slot(upd_pc_i);
            h = m_valid[s] && (m_tag[s] == m_tagof(upd_pc_i));
            if (h && upd_taken_i) begin
                if (m_cnt[s] < CNT_TOP) m_cnt[s] = m_cnt[s] + 1;
                m_tgt[s] = upd_target_i;
            end else if (h) begin
                if (m_cnt[s] > 0) m_cnt[s] = m_cnt[s] - 1;
            end else if (upd_taken_i) begin
                m_valid[s] = 1'b1;
                m_tag[s]   = m_tagof(upd_pc_i);
                m_cnt[s]   = CNT_MID;
                m_tgt[s]   = upd_target_i;
            end
        end
    endfunction

    // ---------------- drive / check helpers ----------------
    task automatic drive(input bit fl, input bit uv, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utg, input bit mis, input logic [31:0] lpc);
        @(negedge clk);
        flush_i       = fl;
        upd_valid_i   = uv;
        upd_pc_i      = upc;
        upd_taken_i   = ut;
        upd_target_i  = utg;
        upd_mispred_i = mis;
        lk_pc_i       = lpc;
        #1;
    endtask

    task automatic commit();
        @(posedge clk);
        if (rst) m_update();
    endtask

    task automatic check(input string name, input bit eh, input bit et, input logic [31:0] etg,
                         input logic [31:0] el, input logic [31:0] em);
        n_vec++;
        if (lk_hit_o !== eh || lk_taken_o !== et || lk_target_o !== etg ||
            lookups_o !== el || mispreds_o !== em) begin
            n_bad++;
            $display("FAIL %s pc=%h: got hit=%b taken=%b target=%h lookups=%0d mispreds=%0d, want hit=%b taken=%b target=%h lookups=%0d mispreds=%0d",
                     name, lk_pc_i, lk_hit_o, lk_taken_o, lk_target_o, lookups_o, mispreds_o,
                     eh, et, etg, el, em);
        end else begin
            $display("ok   %s pc=%h hit=%b taken=%b target=%h lookups=%0d mispreds=%0d",
                     name, lk_pc_i, lk_hit_o, lk_taken_o, lk_target_o, lookups_o, mispreds_o);
        end
    endtask

    task automatic check_model(input string name);
        bit          h;
        bit          t;
        logic [31:0] tg;
        m_lookup(lk_pc_i, h, t, tg);
        check(name, h, t, tg, m_lookups, m_mispreds);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          fl;
        bit          uv;
        logic [31:0] upc;
        bit          ut;
        logic [31:0] utg;
        bit          mis;
        logic [31:0] lpc;
        bit          eh;
        bit          et;
        logic [31:0] etg;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input bit fl, input bit uv, input logic [31:0] upc, input bit ut,
                                input logic [31:0] utg, input bit mis, input logic [31:0] lpc,
                                input bit eh, input bit et, input logic [31:0] etg);
        vec_t v;
        v.fl = fl; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg; v.mis = mis;
        v.lpc = lpc; v.eh = eh; v.et = et; v.etg = etg;
        return v;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = {16'h0, 8'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
        if ($urandom_range(0, 9) == 0) p[31:16] = 16'($urandom);
        return p;
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst           = 1'b0;
        flush_i       = 1'b0;
        upd_valid_i   = 1'b0;
        upd_pc_i      = 32'h0;
        upd_taken_i   = 1'b0;
        upd_target_i  = 32'h0;
        upd_mispred_i = 1'b0;
        lk_pc_i       = 32'h100;
        m_reset();

        // Lookup expectations are written out by hand; columns:
        // flush, upd_valid, upd_pc, taken, target, mispred, lookup_pc, hit, taken, target
        vecs[0]  = mk(0, 1, 32'h100,  1, 32'h200,  1, 32'h100,  0, 0, 32'h104);  // pre-update view
        vecs[1]  = mk(0, 1, 32'h100,  0, 32'h0,    1, 32'h100,  1, 1, 32'h200);
        vecs[2]  = mk(0, 1, 32'h100,  0, 32'h0,    0, 32'h100,  1, 0, 32'h104);
        vecs[3]  = mk(0, 1, 32'h100,  0, 32'h0,    0, 32'h100,  1, 0, 32'h104);
        vecs[4]  = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'h100,  1, 0, 32'h104);  // floor at 0
        vecs[5]  = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'h8100, 0, 0, 32'h8104); // tag alias
        vecs[6]  = mk(0, 1, 32'h100,  1, 32'h240,  0, 32'h100,  1, 0, 32'h104);
        vecs[7]  = mk(0, 1, 32'h100,  1, 32'h240,  0, 32'h100,  1, 0, 32'h104);
        vecs[8]  = mk(0, 1, 32'h100,  1, 32'h240,  1, 32'h100,  1, 1, 32'h240);
        vecs[9]  = mk(0, 1, 32'h100,  1, 32'h240,  0, 32'h100,  1, 1, 32'h240);  // saturate top
        vecs[10] = mk(0, 1, 32'h100,  0, 32'h0,    0, 32'h100,  1, 1, 32'h240);
        vecs[11] = mk(0, 1, 32'h8100, 1, 32'h900,  0, 32'h100,  1, 1, 32'h240);  // evict alias
        vecs[12] = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'h100,  0, 0, 32'h104);
        vecs[13] = mk(1, 1, 32'h300,  1, 32'h500,  1, 32'h8100, 1, 1, 32'h900);  // flush wins
        vecs[14] = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'h8100, 0, 0, 32'h8104);
        vecs[15] = mk(0, 1, 32'h8100, 0, 32'h0,    0, 32'h300,  0, 0, 32'h304);
        vecs[16] = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'h8100, 0, 0, 32'h8104);
        vecs[17] = mk(0, 1, 32'h300,  1, 32'h500,  0, 32'hFFFFFFFC, 0, 0, 32'h0); // pc+4 wrap
        vecs[18] = mk(0, 1, 32'hFFFFFFFC, 1, 32'h1000, 0, 32'h300, 1, 1, 32'h500);
        vecs[19] = mk(0, 0, 32'h0,    0, 32'h0,    0, 32'hFFFFFFFC, 1, 1, 32'h1000);

        // Held in reset: cleared table seen through lookup, counters at zero.
        @(negedge clk);
        @(negedge clk);
        check("reset", 1'b0, 1'b0, 32'h104, 32'h0, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].fl, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utg, vecs[i].mis,
                  vecs[i].lpc);
            check($sformatf("vec%0d", i), vecs[i].eh, vecs[i].et, vecs[i].etg,
                  m_lookups, m_mispreds);
            commit();
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] up;
            logic [31:0] lp;
            up = rand_pc();
            lp = ($urandom_range(0, 1) == 0) ? up : rand_pc();
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, up,
                  $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1, lp);
            check_model($sformatf("rand%0d", i));
            commit();
        end

        // Asynchronous reset with no clock edge, then three mispredicted updates
        // and a reset that lands in the middle of a fourth update.
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h400);
        rst = 1'b0;
        #1;
        m_reset();
        check("async_rst", 1'b0, 1'b0, 32'h404, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 32'h400, 1, 32'h800, 1, 32'h400);
            check_model($sformatf("misp%0d", k));
            commit();
        end
        drive(0, 1, 32'h500, 1, 32'h900, 1, 32'h400);
        check("pre_rst", 1'b1, 1'b1, 32'h800, 32'd3, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        check("mid_rst", 1'b0, 1'b0, 32'h404, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst         = 1'b1;
        upd_valid_i = 1'b0;
        lk_pc_i     = 32'h500;
        #1;
        check("dropped_upd", 1'b0, 1'b0, 32'h504, 32'h0, 32'h0);
        commit();
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h400);
        check("table_clear", 1'b0, 1'b0, 32'h404, 32'h0, 32'h0);
        commit();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
